// File: rtl/tseq_pkg.sv
// Shared types and constants for the count target sequencer.
package tseq_pkg;

  localparam int TSEQ_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } tseq_state_e;

  // Number of WAIT cycles tolerated before the watchdog gives up on a target.
  function automatic int tseq_timeout_limit(input int width);
    return (1 << width) + 2;
  endfunction

endpackage

// File: rtl/count_target_sequencer_if.sv
// Producer push handshake plus the load/feedback path to the counter stage.
interface count_target_sequencer_if
  import tseq_pkg::*;
#(
  parameter int WIDTH = TSEQ_WIDTH
);
  logic             push_valid;
  logic [WIDTH-1:0] push_num;
  logic             push_ready;
  logic [WIDTH-1:0] cnt_num;
  logic             out_valid;
  logic [WIDTH-1:0] out_num;
  logic             done;
  logic             busy;
  logic             err;

  modport master (
    output push_valid, push_num, cnt_num,
    input  push_ready, out_valid, out_num, done, busy, err
  );

  modport slave (
    input  push_valid, push_num, cnt_num,
    output push_ready, out_valid, out_num, done, busy, err
  );
endinterface

// File: rtl/tseq_fifo.sv
// Show-ahead synchronous FIFO; pointers carry one extra wrap bit to tell full from empty.
module tseq_fifo
  import tseq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = TSEQ_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             wr_fire, rd_fire;

  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty   = (wr_ptr == rd_ptr);
  assign wr_fire = wr_en && !full;
  assign rd_fire = rd_en && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/count_target_sequencer.sv
// Buffers count targets, loads them into the counter one at a time, and waits for each to be reached.
// Optional watchdog: define TSEQ_TIMEOUT_EN to abandon a target that is never reached.
module count_target_sequencer
  import tseq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = TSEQ_WIDTH
) (
  input logic                     clk,
  input logic                     rst,
  count_target_sequencer_if.slave bus
);
  tseq_state_e      state, state_nxt;
  logic [WIDTH-1:0] target, head;
  logic             full, empty;
  logic             load, match, timeout;
  logic             out_valid_q, done_q;
  logic [WIDTH-1:0] out_num_q;

  tseq_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (bus.push_valid),
    .wr_data (bus.push_num),
    .rd_en   (state == ISSUE),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  // The counter clears on load, so WAIT never sees a stale match from a previous target.
  assign match = (bus.cnt_num == target);
  assign load  = (state == IDLE) && !empty;

`ifdef TSEQ_TIMEOUT_EN
  localparam logic [WIDTH+1:0] WD_LAST = (WIDTH+2)'(tseq_timeout_limit(WIDTH) - 1);

  logic [WIDTH+1:0] wd;
  logic             err_q;

  assign timeout = (state == WAIT) && !match && (wd == WD_LAST);

  // Held at zero outside WAIT so each target starts with a fresh budget.
  always_ff @(posedge clk) begin
    if (rst || state != WAIT) wd <= '0;
    else                      wd <= wd + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= timeout;
  end

  assign bus.err = err_q;
`else
  assign timeout = 1'b0;
  assign bus.err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (load) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (match || timeout) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      target      <= '0;
      out_valid_q <= 1'b0;
      out_num_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      out_valid_q <= load;
      out_num_q   <= load ? head : '0;
      done_q      <= (state == WAIT) && match;
      if (load) target <= head;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_num    = out_num_q;
  assign bus.done       = done_q;
  assign bus.push_ready = !full;
  assign bus.busy       = (state != IDLE) || !empty;

endmodule

// File: tb/tb_count_target_sequencer.sv
// Directed bench for count_target_sequencer with a simple ramping counter model in the loop.
module tb_count_target_sequencer;
  import tseq_pkg::*;

  localparam int DEPTH = 4;
  localparam int WIDTH = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ramp_en = 1'b1;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;

  logic [WIDTH-1:0] cnt, lim;
  int               iss_cyc[$];
  int               iss_num[$];
  int               done_cyc[$];

  count_target_sequencer_if #(.WIDTH(WIDTH)) ifc ();

  count_target_sequencer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Counter stage: clears on load, then counts up to the loaded value while enabled.
  always @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      lim <= '0;
    end else if (ifc.out_valid) begin
      cnt <= '0;
      lim <= ifc.out_num;
    end else if (ramp_en && cnt != lim) begin
      cnt <= cnt + 1'b1;
    end
  end
  assign ifc.cnt_num = cnt;

  always @(negedge clk) begin
    if (!rst) begin
      if (ifc.out_valid) begin
        iss_cyc.push_back(cyc);
        iss_num.push_back(int'(ifc.out_num));
      end
      if (ifc.done) done_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    iss_cyc.delete();
    iss_num.delete();
    done_cyc.delete();
  endtask

  task automatic push_once(input int val);
    tick();
    ifc.push_valid = 1'b1;
    ifc.push_num   = WIDTH'(val);
    tick();
    ifc.push_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    compared++; if (ifc.push_ready !== 1'b1) begin mismatched++; $display("FAIL reset_push_ready: got %b want 1", ifc.push_ready); end
    compared++; if (ifc.out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid: got %b want 0", ifc.out_valid); end
    compared++; if (ifc.out_num !== 5'd0) begin mismatched++; $display("FAIL reset_out_num: got %0d want 0", ifc.out_num); end
    compared++; if (ifc.done !== 1'b0) begin mismatched++; $display("FAIL reset_done: got %b want 0", ifc.done); end
    compared++; if (ifc.err !== 1'b0) begin mismatched++; $display("FAIL reset_err: got %b want 0", ifc.err); end
    compared++; if (ifc.busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", ifc.busy); end
  endtask

  // Target 3: issue in cycle 2, done in cycle 7, idle from cycle 7 onward.
  task automatic test_single();
    ramp_en = 1'b1;
    push_once(3);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      compared++; if (ifc.out_valid !== (k == 2)) begin mismatched++; $display("FAIL single_out_valid c%0d: got %b want %b", k, ifc.out_valid, (k == 2)); end
      compared++; if (ifc.out_num !== ((k == 2) ? 5'd3 : 5'd0)) begin mismatched++; $display("FAIL single_out_num c%0d: got %0d", k, ifc.out_num); end
      compared++; if (ifc.done !== (k == 7)) begin mismatched++; $display("FAIL single_done c%0d: got %b want %b", k, ifc.done, (k == 7)); end
      compared++; if (ifc.busy !== (k <= 6)) begin mismatched++; $display("FAIL single_busy c%0d: got %b want %b", k, ifc.busy, (k <= 6)); end
      tick();
    end
  endtask

  task automatic test_zero();
    ramp_en = 1'b1;
    push_once(0);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      compared++; if (ifc.out_valid !== (k == 2)) begin mismatched++; $display("FAIL zero_out_valid c%0d: got %b want %b", k, ifc.out_valid, (k == 2)); end
      compared++; if (ifc.done !== (k == 4)) begin mismatched++; $display("FAIL zero_done c%0d: got %b want %b", k, ifc.done, (k == 4)); end
      compared++; if (ifc.busy !== (k <= 3)) begin mismatched++; $display("FAIL zero_busy c%0d: got %b want %b", k, ifc.busy, (k <= 3)); end
      tick();
    end
  endtask

  // A stalled target 7 holds WAIT while 2,5,1,4 fill the FIFO and 6 is refused.
  task automatic test_back_to_back();
    int vals[5];
    int exp_num[5];
    int exp_gap[3];
    vals    = '{2, 5, 1, 4, 6};
    exp_num = '{7, 2, 5, 1, 4};
    exp_gap = '{5, 8, 4};
    ramp_en = 1'b0;
    clear_logs();
    tick();
    ifc.push_valid = 1'b1;
    ifc.push_num   = 5'd7;
    tick();
    for (int i = 0; i < 5; i++) begin
      ifc.push_num = WIDTH'(vals[i]);
      @(negedge clk);
      compared++; if (ifc.push_ready !== (i < 4)) begin mismatched++; $display("FAIL b2b_push_ready #%0d: got %b want %b", i, ifc.push_ready, (i < 4)); end
      tick();
    end
    ifc.push_valid = 1'b0;
    ramp_en = 1'b1;
    repeat (80) tick();
    @(negedge clk);
    compared++; if (iss_num.size() !== 5) begin mismatched++; $display("FAIL b2b_issue_count: got %0d want 5", iss_num.size()); end
    for (int i = 0; i < 5; i++) begin
      if (i < iss_num.size()) begin
        compared++; if (iss_num[i] !== exp_num[i]) begin mismatched++; $display("FAIL b2b_issue_order #%0d: got %0d want %0d", i, iss_num[i], exp_num[i]); end
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (i + 2 < iss_cyc.size()) begin
        compared++; if (iss_cyc[i+2] - iss_cyc[i+1] !== exp_gap[i]) begin mismatched++; $display("FAIL b2b_issue_gap #%0d: got %0d want %0d", i, iss_cyc[i+2] - iss_cyc[i+1], exp_gap[i]); end
      end
    end
    compared++; if (done_cyc.size() !== 5) begin mismatched++; $display("FAIL b2b_done_count: got %0d want 5", done_cyc.size()); end
    compared++; if (ifc.busy !== 1'b0) begin mismatched++; $display("FAIL b2b_busy_end: got %b want 0", ifc.busy); end
    tick();
  endtask

  // FIFO at DEPTH-1 during ISSUE of 1: a push on the pop edge keeps the count at DEPTH-1.
  task automatic test_push_on_pop();
    int  exp_num[6];
    bit  found;
    exp_num = '{3, 1, 2, 4, 8, 9};
    found   = 1'b0;
    ramp_en = 1'b0;
    clear_logs();
    tick();
    ifc.push_valid = 1'b1;
    ifc.push_num = 5'd3; tick();
    ifc.push_num = 5'd1; tick();
    ifc.push_num = 5'd2; tick();
    ifc.push_num = 5'd4; tick();
    ifc.push_valid = 1'b0;
    ramp_en = 1'b1;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (ifc.out_valid && ifc.out_num == 5'd1) found = 1'b1;
      else tick();
    end
    compared++; if (!found) begin mismatched++; $display("FAIL pop_wait_issue: got timeout want issue of 1"); end
    compared++; if (ifc.push_ready !== 1'b1) begin mismatched++; $display("FAIL pop_ready_before: got %b want 1", ifc.push_ready); end
    ifc.push_valid = 1'b1;
    ifc.push_num   = 5'd8;
    @(posedge clk); #1;
    ifc.push_valid = 1'b0;
    @(negedge clk);
    compared++; if (ifc.push_ready !== 1'b1) begin mismatched++; $display("FAIL pop_ready_after: got %b want 1", ifc.push_ready); end
    ifc.push_valid = 1'b1;
    ifc.push_num   = 5'd9;
    @(posedge clk); #1;
    ifc.push_valid = 1'b0;
    @(negedge clk);
    compared++; if (ifc.push_ready !== 1'b0) begin mismatched++; $display("FAIL pop_ready_full: got %b want 0", ifc.push_ready); end
    repeat (100) tick();
    compared++; if (iss_num.size() !== 6) begin mismatched++; $display("FAIL pop_issue_count: got %0d want 6", iss_num.size()); end
    for (int i = 0; i < 6; i++) begin
      if (i < iss_num.size()) begin
        compared++; if (iss_num[i] !== exp_num[i]) begin mismatched++; $display("FAIL pop_issue_order #%0d: got %0d want %0d", i, iss_num[i], exp_num[i]); end
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    ramp_en = 1'b0;
    push_once(31);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    compared++; if (ifc.done !== 1'b0) begin mismatched++; $display("FAIL rstwait_done: got %b want 0", ifc.done); end
    compared++; if (ifc.out_valid !== 1'b0) begin mismatched++; $display("FAIL rstwait_out_valid: got %b want 0", ifc.out_valid); end
    compared++; if (ifc.busy !== 1'b0) begin mismatched++; $display("FAIL rstwait_busy: got %b want 0", ifc.busy); end
    compared++; if (ifc.push_ready !== 1'b1) begin mismatched++; $display("FAIL rstwait_push_ready: got %b want 1", ifc.push_ready); end
    ramp_en = 1'b1;
    push_once(1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      compared++; if (ifc.out_valid !== (k == 2)) begin mismatched++; $display("FAIL rstwait_reissue c%0d: got %b want %b", k, ifc.out_valid, (k == 2)); end
      compared++; if (ifc.done !== (k == 5)) begin mismatched++; $display("FAIL rstwait_done1 c%0d: got %b want %b", k, ifc.done, (k == 5)); end
      tick();
    end
  endtask

  // Counter held at 0 against target 7: 34 WAIT cycles (cycles 3..36) then err in cycle 37.
  task automatic test_timeout();
    ramp_en = 1'b0;
    push_once(7);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      compared++; if (ifc.done !== 1'b0) begin mismatched++; $display("FAIL timeout_done c%0d: got %b want 0", k, ifc.done); end
`ifdef TSEQ_TIMEOUT_EN
      compared++; if (ifc.err !== (k == 37)) begin mismatched++; $display("FAIL timeout_err c%0d: got %b want %b", k, ifc.err, (k == 37)); end
      compared++; if (ifc.busy !== (k <= 36)) begin mismatched++; $display("FAIL timeout_busy c%0d: got %b want %b", k, ifc.busy, (k <= 36)); end
`else
      compared++; if (ifc.err !== 1'b0) begin mismatched++; $display("FAIL noto_err c%0d: got %b want 0", k, ifc.err); end
      compared++; if (ifc.busy !== 1'b1) begin mismatched++; $display("FAIL noto_busy c%0d: got %b want 1", k, ifc.busy); end
`endif
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ramp_en = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: got no finish want finish");
    $fatal(1);
  end

  initial begin
    ifc.push_valid = 1'b0;
    ifc.push_num   = '0;
    test_reset();
    test_single();
    test_zero();
    test_back_to_back();
    test_push_on_pop();
    test_reset_mid_wait();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/count_target_sequencer.md
# count_target_sequencer

Upstream feeder for the counter stage. Accepts a stream of count targets from a producer, buffers them in a small FIFO, and issues them one at a time to the counter as a single-cycle `in_valid`/`in_num` load. It then watches the counter's output until the count reaches the target, pulses `done`, and issues the next buffered target.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `WIDTH`, 5: target and count width; matches counter `in_num`/`out_num`.

- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `push_valid`  in  1  producer offers a target.
- `push_num`  in  WIDTH  target value.
- `push_ready`  out  1  FIFO can accept; equals `!full`.
- `cnt_num`  in  WIDTH  counter's `out_num`, fed back.
- `out_valid`  out  1  load strobe to counter `in_valid`.
- `out_num`  out  WIDTH  target to counter `in_num`.
- `done`  out  1  one-cycle pulse: current target reached.
- `busy`  out  1  `state != IDLE || !empty`.
- `err`  out  1  one-cycle timeout pulse; see Configuration.

## Operation
- Push accepted on an edge where `push_valid && push_ready`. A push while full is ignored and not stored.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE → ISSUE when the FIFO is non-empty. On that edge, load `out_num` with the head entry and the internal `target` register with the same value.
  - ISSUE lasts exactly one cycle: `out_valid=1`; the FIFO pops on the ISSUE→WAIT edge; `out_num` returns to 0.
  - WAIT compares `cnt_num == target`. On a match, go to IDLE and register `done=1` for one cycle.
- Entering WAIT starts one cycle after the counter's load edge, so `cnt_num` is already cleared to 0. No stale match from the previous run is possible.
- Target 0 matches in the first WAIT cycle.
- `push_ready` is `!full` only. A push on the same edge as a pop while full is still refused. A push on the pop edge when not full is accepted normally.
- Reset (edge with `rst=1`) forces:
  - FIFO empty, state IDLE.
  - `out_valid=0`, `out_num=0`, `done=0`, `err=0`, `busy=0`.
  - `push_ready=1` in the first cycle after reset.
- Reset mid-WAIT abandons the target without `done`. The counter is reset separately.
- FIFO pointers are log2(DEPTH)+1 bits and wrap modulo 2·DEPTH. Full when the addresses match and the MSBs differ.

## Timing
Cycle k means the period after edge k. Push is presented in cycle 0 and sampled at edge 0.
- Cycle 1: IDLE, non-empty.
- Cycle 2: ISSUE, `out_valid=1`, `out_num=N`.
- Cycle 3: WAIT, `cnt_num=0`.
- Cycle 3+N: `cnt_num=N`, match.
- Cycle 4+N: `done=1`, state IDLE.
- With the FIFO non-empty, the next ISSUE is in cycle 5+N. Per-target period is N+3 cycles.
- All outputs are registered except `push_ready` and `busy`, which are combinational from registers.

## Configuration
- `TSEQ_TIMEOUT_EN` defined:
  - A watchdog counter of WIDTH+2 bits runs in WAIT.
  - If no match occurs within 2^WIDTH+2 WAIT cycles, go to IDLE, pulse `err=1` for one cycle, and do not assert `done`.
  - The watchdog clears on entering WAIT.
- Not defined: watchdog absent, `err` tied 0, and WAIT is held indefinitely until a match.

## Structure
- `tseq_pkg`: state enum `tseq_state_e` (IDLE, ISSUE, WAIT), default `TSEQ_WIDTH=5`, and timeout-limit function of WIDTH.
- Sub-module `tseq_fifo`: synchronous FIFO with parameters DEPTH/WIDTH.
  - Ports: `clk`, `rst`, `wr_en`, `wr_data`, `rd_en`, `rd_data` (head, show-ahead), `full`, `empty`.
- Top holds the FSM, the `target` register, and the watchdog.

## Test plan
- Reset then push 3 in cycle 0 → `out_valid` in cycle 2 with `out_num=3`; counter ramps 0..3; `done` in cycle 7 only; `busy` low in cycle 8.
- Push 0 → `done` exactly 2 cycles after `out_valid`; no spurious second issue.
- Push 2, 5, 1, 4, 6 back-to-back with the counter stalled at load → first four accepted, fifth refused (`push_ready=0`); issue order 2, 5, 1, 4; issues at N+3 spacing.
- Push in the same cycle as the ISSUE pop with the FIFO at DEPTH-1 → accepted; entry count unchanged.
- Assert `rst` during WAIT for target 31 → next cycle: no `done`, `out_valid=0`, `busy=0`; a new push of 1 completes normally.
- With `TSEQ_TIMEOUT_EN` defined, hold `cnt_num=0` against target 7 → `err` pulse after 34 WAIT cycles, no `done`; without the macro, `err` never asserts.
